// File: rtl/store_drain_unit.sv
// Drains committed stores from the store buffer head into the data-cache write port; 4 cycles min per store.
// Holds dc_req_* stable while dc_req_ready is low; the head is popped only after dc_wr_done.
module store_drain_unit #(
  parameter int ENTRY_COUNT = 4,
  parameter int HIGH_WATER  = 3,
  localparam int CW = $clog2(ENTRY_COUNT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sb_deq_valid,
  input  logic [31:0]   sb_deq_addr,
  input  logic [31:0]   sb_deq_data,
  input  logic [CW-1:0] sb_count,
  output logic          sb_deq_req,
  output logic          dc_req_valid,
  input  logic          dc_req_ready,
  output logic [31:0]   dc_req_addr,
  output logic [31:0]   dc_req_data,
  input  logic          dc_wr_done,
  input  logic          load_busy,
  input  logic          fence_req,
  output logic          fence_done,
  input  logic          flush,
  output logic          busy,
  output logic [31:0]   drained_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_POP,
    S_ABORT
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_entry_t;

  localparam logic [CW-1:0] HW_LVL = CW'(HIGH_WATER);

  state_t    state, state_nxt;
  st_entry_t req_q;
  logic      start;
  logic      latch_en;
  logic      cnt_inc;

  // Loads keep the port unless the buffer is nearly full or a fence needs it empty.
  assign start = sb_deq_valid && !flush &&
                 (!load_busy || (sb_count >= HW_LVL) || fence_req);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      req_q       <= '0;
      drained_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        req_q <= '{addr: sb_deq_addr, data: sb_deq_data};
      end
      if (cnt_inc) begin
        drained_cnt <= drained_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    latch_en     = 1'b0;
    cnt_inc      = 1'b0;
    sb_deq_req   = 1'b0;
    dc_req_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch_en  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // Valid is masked by flush so a same-cycle ready cannot complete a handshake.
        dc_req_valid = !flush;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (dc_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dc_wr_done) begin
          state_nxt = flush ? S_IDLE : S_POP;
        end else if (flush) begin
          state_nxt = S_ABORT;
        end
      end
      S_POP: begin
        sb_deq_req = !flush;
        cnt_inc    = !flush;
        state_nxt  = S_IDLE;
      end
      S_ABORT: begin
        // The accepted write must still complete before the port is reused.
        if (dc_wr_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dc_req_addr = req_q.addr;
  assign dc_req_data = req_q.data;
  assign busy        = (state != S_IDLE);
  assign fence_done  = fence_req && (state == S_IDLE) && (sb_count == '0);

endmodule

// File: tb/tb_store_drain_unit.sv
// Directed-vector bench for store_drain_unit with a small queue standing in for the store buffer.
module tb_store_drain_unit;

  logic        clock;
  logic        reset;
  logic        sb_deq_valid;
  logic [31:0] sb_deq_addr;
  logic [31:0] sb_deq_data;
  logic [2:0]  sb_count;
  logic        sb_deq_req;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_data;
  logic        dc_wr_done;
  logic        load_busy;
  logic        fence_req;
  logic        fence_done;
  logic        flush;
  logic        busy;
  logic [31:0] drained_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  store_drain_unit dut (
    .clock        (clock),
    .reset        (reset),
    .sb_deq_valid (sb_deq_valid),
    .sb_deq_addr  (sb_deq_addr),
    .sb_deq_data  (sb_deq_data),
    .sb_count     (sb_count),
    .sb_deq_req   (sb_deq_req),
    .dc_req_valid (dc_req_valid),
    .dc_req_ready (dc_req_ready),
    .dc_req_addr  (dc_req_addr),
    .dc_req_data  (dc_req_data),
    .dc_wr_done   (dc_wr_done),
    .load_busy    (load_busy),
    .fence_req    (fence_req),
    .fence_done   (fence_done),
    .flush        (flush),
    .busy         (busy),
    .drained_cnt  (drained_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_update();
    sb_deq_valid = (q_addr.size() != 0);
    sb_deq_addr  = sb_deq_valid ? q_addr[0] : 32'h0;
    sb_deq_data  = sb_deq_valid ? q_data[0] : 32'h0;
    sb_count     = 3'(q_addr.size());
  endtask

  task automatic sb_push(input logic [31:0] a, input logic [31:0] d);
    q_addr.push_back(a);
    q_data.push_back(d);
    sb_update();
  endtask

  task automatic sb_clear();
    q_addr.delete();
    q_data.delete();
    sb_update();
  endtask

  // Starts from IDLE with a startable head; ends in IDLE after the pop.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                           input int rdy_wait, input int done_wait, input string tag);
    dc_req_ready = 1'b0;
    tick();
    for (int i = 0; i <= rdy_wait; i++) begin
      dc_req_ready = (i == rdy_wait);
      check({tag, ".req_valid"}, 64'(dc_req_valid), 64'(1));
      check({tag, ".req_addr"}, 64'(dc_req_addr), 64'(a));
      check({tag, ".req_data"}, 64'(dc_req_data), 64'(d));
      check({tag, ".req_nopop"}, 64'(sb_deq_req), 64'(0));
      check({tag, ".req_busy"}, 64'(busy), 64'(1));
      check({tag, ".req_fence"}, 64'(fence_done), 64'(0));
      tick();
    end
    dc_req_ready = 1'b0;
    for (int i = 0; i < done_wait; i++) begin
      check({tag, ".wait_valid"}, 64'(dc_req_valid), 64'(0));
      check({tag, ".wait_nopop"}, 64'(sb_deq_req), 64'(0));
      dc_wr_done = (i == done_wait - 1);
      tick();
    end
    dc_wr_done = 1'b0;
    check({tag, ".pop"}, 64'(sb_deq_req), 64'(1));
    q_addr.pop_front();
    q_data.pop_front();
    sb_update();
    tick();
    check({tag, ".idle_nopop"}, 64'(sb_deq_req), 64'(0));
    check({tag, ".idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    dc_req_ready = 1'b0;
    dc_wr_done = 1'b0;
    load_busy = 1'b0;
    fence_req = 1'b0;
    flush = 1'b0;
    sb_update();
    #2;
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.valid", 64'(dc_req_valid), 64'(0));
    check("rst.pop", 64'(sb_deq_req), 64'(0));
    check("rst.cnt", 64'(drained_cnt), 64'(0));
    check("rst.addr", 64'(dc_req_addr), 64'(0));
    #10 reset = 1'b0;
    tick();

    // 1: single store, done two cycles after acceptance
    sb_push(32'h100, 32'hDEADBEEF);
    run_store(32'h100, 32'hDEADBEEF, 0, 2, "t1");
    check("t1.cnt", 64'(drained_cnt), 64'(1));

    // 2: three cycles of backpressure
    sb_push(32'h104, 32'hCAFEF00D);
    run_store(32'h104, 32'hCAFEF00D, 3, 1, "t2");
    check("t2.cnt", 64'(drained_cnt), 64'(2));

    // 3: load_busy holds off below the high-water mark
    load_busy = 1'b1;
    sb_push(32'h20, 32'hA);
    sb_push(32'h24, 32'hB);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3.hold_busy", 64'(busy), 64'(0));
      check("t3.hold_valid", 64'(dc_req_valid), 64'(0));
    end
    sb_push(32'h28, 32'hC);
    run_store(32'h20, 32'hA, 0, 1, "t3a");
    tick();
    check("t3.below_hw", 64'(busy), 64'(0));
    load_busy = 1'b0;
    run_store(32'h24, 32'hB, 0, 1, "t3b");
    run_store(32'h28, 32'hC, 0, 1, "t3c");
    check("t3.cnt", 64'(drained_cnt), 64'(5));

    // 4: fence drains everything despite load_busy
    load_busy = 1'b1;
    fence_req = 1'b1;
    sb_push(32'h10, 32'h1);
    sb_push(32'h14, 32'h2);
    sb_push(32'h18, 32'h3);
    #1;
    check("t4.fence_early", 64'(fence_done), 64'(0));
    run_store(32'h10, 32'h1, 0, 1, "t4a");
    check("t4.fence_mid", 64'(fence_done), 64'(0));
    run_store(32'h14, 32'h2, 1, 1, "t4b");
    run_store(32'h18, 32'h3, 0, 1, "t4c");
    check("t4.fence_done", 64'(fence_done), 64'(1));
    check("t4.cnt", 64'(drained_cnt), 64'(8));
    fence_req = 1'b0;
    load_busy = 1'b0;
    #1;
    check("t4.fence_off", 64'(fence_done), 64'(0));

    // 5a: flush in WAIT, second flush in ABORT ignored
    sb_push(32'h30, 32'h33);
    dc_req_ready = 1'b1;
    tick();
    check("t5a.req", 64'(dc_req_valid), 64'(1));
    tick();
    dc_req_ready = 1'b0;
    flush = 1'b1;
    sb_clear();
    tick();
    flush = 1'b0;
    check("t5a.abort_busy", 64'(busy), 64'(1));
    check("t5a.abort_valid", 64'(dc_req_valid), 64'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5a.abort_hold", 64'(busy), 64'(1));
    dc_wr_done = 1'b1;
    #1;
    check("t5a.done_nopop", 64'(sb_deq_req), 64'(0));
    tick();
    dc_wr_done = 1'b0;
    check("t5a.idle", 64'(busy), 64'(0));
    check("t5a.nopop", 64'(sb_deq_req), 64'(0));
    check("t5a.cnt", 64'(drained_cnt), 64'(8));

    // 5b: flush in REQ beats a same-cycle ready
    sb_push(32'h40, 32'h44);
    tick();
    check("t5b.req", 64'(dc_req_valid), 64'(1));
    flush = 1'b1;
    dc_req_ready = 1'b1;
    sb_clear();
    #1;
    check("t5b.masked", 64'(dc_req_valid), 64'(0));
    tick();
    flush = 1'b0;
    dc_req_ready = 1'b0;
    check("t5b.idle", 64'(busy), 64'(0));
    tick();
    check("t5b.stay", 64'(busy), 64'(0));

    // 5c: done and flush together in WAIT return to IDLE without a pop
    sb_push(32'h50, 32'h55);
    dc_req_ready = 1'b1;
    tick();
    tick();
    dc_req_ready = 1'b0;
    dc_wr_done = 1'b1;
    flush = 1'b1;
    sb_clear();
    tick();
    dc_wr_done = 1'b0;
    flush = 1'b0;
    check("t5c.idle", 64'(busy), 64'(0));
    check("t5c.nopop", 64'(sb_deq_req), 64'(0));
    check("t5c.cnt", 64'(drained_cnt), 64'(8));

    // 6: asynchronous reset in REQ
    sb_push(32'h200, 32'h55);
    tick();
    check("t6.req", 64'(dc_req_valid), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("t6.valid_drop", 64'(dc_req_valid), 64'(0));
    check("t6.busy_drop", 64'(busy), 64'(0));
    check("t6.cnt_clear", 64'(drained_cnt), 64'(0));
    check("t6.addr_clear", 64'(dc_req_addr), 64'(0));
    sb_clear();
    @(posedge clock);
    #3 reset = 1'b0;
    tick();
    check("t6.post_busy", 64'(busy), 64'(0));
    check("t6.post_valid", 64'(dc_req_valid), 64'(0));
    check("t6.post_pop", 64'(sb_deq_req), 64'(0));
    check("t6.post_data", 64'(dc_req_data), 64'(0));
    check("t6.post_cnt", 64'(drained_cnt), 64'(0));
    check("t6.post_fence", 64'(fence_done), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_drain_unit.md
Name: store_drain_unit

Overview:
Drain side of the core's store buffer. Pops committed stores from the buffer head one at a time and writes them to the data-cache write port using a valid/ready request and a completion pulse. An entry is popped only after the cache signals completion, so load forwarding still sees the store while its write is in flight. Also provides fence support (drain everything) and flush/exception abort handling.

Parameters:
ENTRY_COUNT, 4, store buffer depth; sets the width CW = $clog2(ENTRY_COUNT+1) of sb_count.
HIGH_WATER, 3, occupancy at or above which draining ignores load_busy (1..ENTRY_COUNT).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
sb_deq_valid  in  1  store buffer head entry is valid
sb_deq_addr  in  32  head entry address
sb_deq_data  in  32  head entry data
sb_count  in  CW  store buffer occupancy
sb_deq_req  out  1  pop request for the head entry (single-cycle pulse)
dc_req_valid  out  1  cache write request valid
dc_req_ready  in  1  cache accepts the request
dc_req_addr  out  32  write address
dc_req_data  out  32  write data
dc_wr_done  in  1  cache write complete (pulse)
load_busy  in  1  load currently owns the cache port
fence_req  in  1  fence pending; drain regardless of load_busy
fence_done  out  1  fence may retire
flush  in  1  pipeline flush or exception; store buffer clears this cycle
busy  out  1  FSM not in IDLE
drained_cnt  out  32  count of stores retired to the cache

Behaviour:
- Reset (async): FSM=IDLE; addr/data latches=0; all outputs 0; drained_cnt=0. Reset asserted mid-operation abandons any in-flight write; the cache shares this reset.
- FSM states: IDLE, REQ, WAIT, POP, ABORT.
- IDLE:
  - start = sb_deq_valid && !flush && (!load_busy || sb_count>=HIGH_WATER || fence_req).
  - On start: latch sb_deq_addr/sb_deq_data, go to REQ.
- REQ:
  - dc_req_valid=1; dc_req_addr/dc_req_data driven from the latches, held stable until handshake.
  - dc_req_valid && dc_req_ready -> WAIT.
  - flush before handshake -> IDLE, no request issued. Flush has priority over a same-cycle ready.
- WAIT:
  - Waits for dc_wr_done. The cache never asserts done in the acceptance cycle; dc_wr_done is ignored outside WAIT/ABORT.
  - done && !flush -> POP.
  - flush without done -> ABORT.
  - done && flush -> IDLE, no pop.
- POP:
  - sb_deq_req=1 for exactly this cycle; drained_cnt+=1 (wraps at 2^32); -> IDLE.
  - If flush is high in POP: sb_deq_req=0, no increment, -> IDLE.
- ABORT: wait for dc_wr_done, then -> IDLE. No pop, no increment. A second flush here is ignored.
- Minimum cost is 4 cycles per store (IDLE, REQ, WAIT, POP). The next store starts in the cycle after POP, when sb_deq_addr already reflects the new head.
- fence_done (combinational) = fence_req && state==IDLE && sb_count==0.
- busy = (state != IDLE).
- drained_cnt is not cleared by flush.
- Width rule: sb_count is compared unsigned against HIGH_WATER at CW bits.

Test Plan:
1. Single store: sb_deq_valid=1, addr=0x100, data=0xDEADBEEF, ready=1, done 2 cycles after acceptance -> dc_req_valid for 1 cycle with 0x100/0xDEADBEEF; one sb_deq_req pulse the cycle after done; drained_cnt=1.
2. Backpressure: dc_req_ready=0 for 3 cycles -> dc_req_valid held 4 cycles with addr/data stable; no sb_deq_req until after done.
3. Priority: load_busy=1, sb_count=2 -> stays IDLE, busy=0. Raise sb_count to 3 -> drain starts next cycle despite load_busy.
4. Fence: 3 entries (0x10/1, 0x14/2, 0x18/3), fence_req=1, load_busy=1 -> three in-order writes and three pops; fence_done=1 only once sb_count==0 and IDLE; drained_cnt=3.
5. Flush in WAIT -> ABORT; a later dc_wr_done -> IDLE with no sb_deq_req; drained_cnt unchanged. Flush in REQ with ready=1 the same cycle -> no handshake, IDLE.
6. Reset asserted asynchronously in REQ -> dc_req_valid drops immediately; after release: IDLE, drained_cnt=0, all outputs 0.
